// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
package onehot_pkg;

  localparam int unsigned MaxReq = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // OR of the indices of all set bits; exact for one-hot and zero inputs.
  function automatic logic [4:0] onehot2bin(input logic [MaxReq-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

  // Sequential scan ptr+1, ptr+2, ... modulo n; first set bit wins.
  function automatic rr_pick_t rr_next(input logic [MaxReq-1:0] req,
                                       input int unsigned       ptr,
                                       input int unsigned       n);
    rr_pick_t    res;
    int unsigned k;
    res = '0;
    for (int unsigned off = 1; off <= MaxReq; off++) begin
      if (off <= n) begin
        k = (ptr + off) % n;
        if (!res.found && req[k[4:0]]) begin
          res.found = 1'b1;
          res.idx   = k[4:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority pick: rotate req so ptr+1 lands at bit 0, take the lowest
// set bit, then rotate the index back.
module rr_priority_pick
  import onehot_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_found
);

  localparam logic [NUM_REQ-1:0] One = NUM_REQ'(1);

  int unsigned        w_shift;
  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_low;
  logic [4:0]         w_ridx;

  always_comb begin
    w_shift = 32'(i_ptr) + 32'd1;
    if (w_shift >= NUM_REQ) w_shift = 0;
    w_rot   = (i_req >> w_shift) | (i_req << (NUM_REQ - w_shift));
    w_low   = w_rot & (~w_rot + One);
    w_ridx  = onehot2bin(MaxReq'(w_low));
    o_idx   = ID_W'((32'(w_ridx) + w_shift) % NUM_REQ);
    o_found = |i_req;
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter driving a registered one-hot mux select.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module onehot_rr_arbiter
  import onehot_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ack_i,
  output logic [NUM_REQ-1:0] sel_o,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
`ifdef ARB_TIMEOUT_EN
  ,
  output logic               timeout_o
`endif
);

  localparam logic [NUM_REQ-1:0] One     = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    PtrInit = ID_W'(NUM_REQ - 1);

  arb_state_t         r_state, w_state_d;
  logic [NUM_REQ-1:0] r_sel, w_sel_d;
  logic               r_valid, w_valid_d;
  logic [ID_W-1:0]    r_id, w_id_d;
  logic [ID_W-1:0]    r_ptr, w_ptr_d;
  logic [ID_W-1:0]    w_idx;
  logic               w_found;
  logic               w_tmo;
  logic               w_ack;
  rr_pick_t           w_ref;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TmoW-1:0] r_cnt, w_cnt_d;
  logic            r_tmo, w_tmo_d;

  // An explicit ack in the final cycle wins over the watchdog.
  assign w_tmo = (r_state == GRANT) && !ack_i && (r_cnt == TmoW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  assign w_ack = ack_i | w_tmo;

  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_valid_d = r_valid;
    w_id_d    = r_id;
    w_ptr_d   = r_ptr;
`ifdef ARB_TIMEOUT_EN
    w_cnt_d   = r_cnt;
    w_tmo_d   = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_d = GRANT;
          w_sel_d   = One << w_idx;
          w_valid_d = 1'b1;
          w_id_d    = w_idx;
          w_ptr_d   = w_idx;
`ifdef ARB_TIMEOUT_EN
          w_cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (w_ack) begin
`ifdef ARB_TIMEOUT_EN
          w_tmo_d = w_tmo;
          w_cnt_d = '0;
`endif
          if (w_found) begin
            w_sel_d = One << w_idx;
            w_id_d  = w_idx;
            w_ptr_d = w_idx;
          end else begin
            w_state_d = IDLE;
            w_sel_d   = '0;
            w_valid_d = 1'b0;
            w_id_d    = '0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          w_cnt_d = r_cnt + 1'b1;
`endif
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= PtrInit;
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
      r_valid <= w_valid_d;
      r_id    <= w_id_d;
      r_ptr   <= w_ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_tmo <= w_tmo_d;
    end
  end

  assign timeout_o = r_tmo;
`endif

  assign sel_o   = r_sel;
  assign valid_o = r_valid;
  assign id_o    = r_id;

  // Reference scan cross-checks the rotating pick.
  always_comb begin
    w_ref = rr_next(MaxReq'(req_i), 32'(r_ptr), NUM_REQ);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (NUM_REQ >= 2 && NUM_REQ <= MaxReq && TIMEOUT_CYCLES >= 2);
      assert ($onehot0(r_sel));
      assert (r_valid == (|r_sel));
      assert (r_valid ? (r_sel == (One << r_id)) : (r_id == '0));
      assert (w_ref.found == w_found && (!w_found || w_ref.idx == 5'(w_idx)));
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed and randomised checks for onehot_rr_arbiter (ARB_TIMEOUT_EN aware).
module tb_onehot_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TC   = 4;
  localparam int HOLD = 3;
`else
  localparam int TC   = 16;
  localparam int HOLD = 5;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic       ack = 1'b0;
  logic [3:0] sel;
  logic       valid;
  logic [1:0] id;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onehot_rr_arbiter #(
    .NUM_REQ        (4),
    .ID_W           (2),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .req_i     (req),
    .ack_i     (ack),
    .sel_o     (sel),
    .valid_o   (valid),
    .id_o      (id)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_o (timeout)
`endif
  );

`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = '0;
    ack = 1'b0;
    rst = 1'b1;
    #3;
    total++;
    if (sel !== 4'b0000 || valid !== 1'b0 || id !== 2'd0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset sel=%b valid=%b id=%0d tmo=%b want 0000/0/0/0",
               sel, valid, id, timeout);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_hold();
    req = 4'b0001;
    step();
    total++;
    if (sel !== 4'b0001 || valid !== 1'b1 || id !== 2'd0) begin
      bad++;
      $display("FAIL single_grant sel=%b valid=%b id=%0d want 0001/1/0", sel, valid, id);
    end
    for (int i = 0; i < HOLD; i++) begin
      step();
      total++;
      if (sel !== 4'b0001 || valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_%0d sel=%b valid=%b want 0001/1", i, sel, valid);
      end
    end
    req = 4'b0000;
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++;
    if (sel !== 4'b0000 || valid !== 1'b0 || id !== 2'd0) begin
      bad++;
      $display("FAIL release sel=%b valid=%b id=%0d want 0000/0/0", sel, valid, id);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    step();
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      total++;
      if (sel !== exp_seq[i] || valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b_%0d sel=%b valid=%b want %b/1", i, sel, valid, exp_seq[i]);
      end
    end
    req = 4'b0000;
    step();
    ack = 1'b0;
    total++;
    if (sel !== 4'b0000 || valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle sel=%b valid=%b want 0000/0", sel, valid);
    end
  endtask

  // Entered with ptr=0 from the previous test.
  task automatic test_wrap();
    req = 4'b0100;
    step();
    total++;
    if (sel !== 4'b0100 || id !== 2'd2) begin
      bad++;
      $display("FAIL wrap_first sel=%b id=%0d want 0100/2", sel, id);
    end
    req = 4'b0011;
    ack = 1'b1;
    step();
    total++;
    if (sel !== 4'b0001 || id !== 2'd0 || valid !== 1'b1) begin
      bad++;
      $display("FAIL wrap_bit0 sel=%b id=%0d valid=%b want 0001/0/1", sel, id, valid);
    end
    req = 4'b0000;
    step();
    total++;
    if (sel !== 4'b0000 || valid !== 1'b0 || id !== 2'd0) begin
      bad++;
      $display("FAIL wrap_idle sel=%b valid=%b id=%0d want 0000/0/0", sel, valid, id);
    end
    step();
    ack = 1'b0;
    total++;
    if (sel !== 4'b0000 || valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_ack sel=%b valid=%b want 0000/0", sel, valid);
    end
  endtask

  // Entered with ptr=0; the grant on bit 2 leaves ptr=2 before reset.
  task automatic test_hold_reset();
    req = 4'b0100;
    step();
    req = 4'b0001;
    step();
    total++;
    if (sel !== 4'b0100 || id !== 2'd2) begin
      bad++;
      $display("FAIL hold_drop sel=%b id=%0d want 0100/2", sel, id);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (sel !== 4'b0000 || valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset sel=%b valid=%b want 0000/0", sel, valid);
    end
    rst = 1'b0;
    req = 4'b1001;
    step();
    total++;
    if (sel !== 4'b0001 || id !== 2'd0) begin
      bad++;
      $display("FAIL ptr_restored sel=%b id=%0d want 0001/0", sel, id);
    end
    req = 4'b1000;
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++;
    if (sel !== 4'b1000 || id !== 2'd3) begin
      bad++;
      $display("FAIL post_reset_grant sel=%b id=%0d want 1000/3", sel, id);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (sel !== 4'b0001 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL tmo_hold_%0d sel=%b tmo=%b want 0001/0", i, sel, timeout);
      end
    end
    step();
    total++;
    if (sel !== 4'b0010 || timeout !== 1'b1) begin
      bad++;
      $display("FAIL tmo_fire sel=%b tmo=%b want 0010/1", sel, timeout);
    end
    step();
    total++;
    if (sel !== 4'b0010 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL tmo_pulse sel=%b tmo=%b want 0010/0", sel, timeout);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] m_sel;
    int         m_ptr;
    logic       m_busy;
    int         m_cnt;
    int         wait_c [4];
    logic       arb, found, m_tmo;
    int         w, k;
    do_reset();
    m_sel  = '0;
    m_ptr  = 3;
    m_busy = 1'b0;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) wait_c[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      ack   = ($urandom_range(0, 2) == 0);
      arb   = !m_busy || ack;
      m_tmo = 1'b0;
`ifdef ARB_TIMEOUT_EN
      if (m_busy && !ack) begin
        if (m_cnt == TC - 1) begin
          arb   = 1'b1;
          m_tmo = 1'b1;
        end else begin
          m_cnt++;
        end
      end
`endif
      found = 1'b0;
      w     = 0;
      if (arb) begin
        for (int off = 1; off <= 4; off++) begin
          k = (m_ptr + off) % 4;
          if (!found && req[k]) begin
            found = 1'b1;
            w     = k;
          end
        end
      end
      if (arb && found) begin
        m_sel  = 4'b0001 << w;
        m_ptr  = w;
        m_busy = 1'b1;
        m_cnt  = 0;
      end else if (arb && m_busy) begin
        m_sel  = '0;
        m_busy = 1'b0;
        m_cnt  = 0;
      end
      for (int r = 0; r < 4; r++) begin
        if (!req[r] || (arb && found && w == r)) wait_c[r] = 0;
        else if (arb && found) wait_c[r]++;
      end
      step();
      total++;
      if (sel !== m_sel || valid !== m_busy || id !== (m_busy ? 2'(m_ptr) : 2'd0)) begin
        bad++;
        $display("FAIL rand_%0d sel=%b valid=%b id=%0d want %b/%b/%0d", cyc, sel, valid, id,
                 m_sel, m_busy, m_busy ? m_ptr : 0);
      end
      total++;
      if (!$onehot0(sel) || valid !== (|sel) || timeout !== m_tmo) begin
        bad++;
        $display("FAIL rand_inv_%0d sel=%b valid=%b tmo=%b want onehot0/%b/%b", cyc, sel,
                 valid, timeout, |sel, m_tmo);
      end
      for (int r = 0; r < 4; r++) begin
        total++;
        if (wait_c[r] > 3) begin
          bad++;
          $display("FAIL fair_%0d req%0d waited=%0d grants want <=3", cyc, r, wait_c[r]);
        end
      end
    end
    ack = 1'b0;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_back_to_back();
    test_wrap();
    test_hold_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
